// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: mode encodings, order/tap tables and mask helpers.
// Used by the transmit generator and the receive-side BER checker.
package prbs_pkg;

    localparam int unsigned LFSR_W    = 31;
    localparam int unsigned NUM_MODES = 5;

    typedef enum logic [2:0] {
        PRBS7_MODE  = 3'd0,
        PRBS9_MODE  = 3'd1,
        PRBS15_MODE = 3'd2,
        PRBS23_MODE = 3'd3,
        PRBS31_MODE = 3'd4
    } prbs_mode_e;

    // Indexed by prbs_mode_e: polynomial x^N + x^M + 1.
    localparam int unsigned ORDER_TBL [NUM_MODES] = '{7, 9, 15, 23, 31};
    localparam int unsigned TAP_TBL   [NUM_MODES] = '{6, 5, 14, 18, 28};

    // Unused encodings fall back to PRBS9.
    function automatic prbs_mode_e mode_decode(input logic [2:0] raw);
        prbs_mode_e m;
        m = PRBS9_MODE;
        if (raw <= 3'd4) begin
            m = prbs_mode_e'(raw);
        end
        return m;
    endfunction

    function automatic logic [LFSR_W-1:0] order_mask(input prbs_mode_e mode);
        logic [LFSR_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LFSR_W; i++) begin
            if (i < ORDER_TBL[mode]) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [LFSR_W-1:0] top_bit(input prbs_mode_e mode);
        logic [LFSR_W-1:0] v;
        v = '0;
        v[ORDER_TBL[mode]-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [LFSR_W-1:0] tap_bit(input prbs_mode_e mode);
        logic [LFSR_W-1:0] v;
        v = '0;
        v[TAP_TBL[mode]-1] = 1'b1;
        return v;
    endfunction

    // All-zero state would lock the LFSR, so substitute all-ones.
    function automatic logic [LFSR_W-1:0] guard_seed(input logic [LFSR_W-1:0] seed,
                                                     input prbs_mode_e mode);
        logic [LFSR_W-1:0] m;
        m = seed & order_mask(mode);
        if (m == '0) begin
            m = order_mask(mode);
        end
        return m;
    endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational NB_OUT-step advance of the multi-polynomial Fibonacci LFSR.
// bits[NB_OUT-1] is the first bit out of the sequence.
module prbs_step
    import prbs_pkg::*;
#(
    parameter int unsigned NB_OUT = 2
) (
    input  logic [LFSR_W-1:0] state,
    input  prbs_mode_e        mode,
    output logic [LFSR_W-1:0] next_state,
    output logic [NB_OUT-1:0] bits
);

    logic [LFSR_W-1:0] mask;
    logic [LFSR_W-1:0] top_sel;
    logic [LFSR_W-1:0] tap_sel;
    logic [LFSR_W-1:0] s;
    logic              out_b;
    logic              fb;

    assign mask    = order_mask(mode);
    assign top_sel = top_bit(mode);
    assign tap_sel = tap_bit(mode);

    // One-hot selects avoid a variable-index mux on the shifting state.
    always_comb begin
        s     = state & mask;
        bits  = '0;
        out_b = 1'b0;
        fb    = 1'b0;
        for (int unsigned i = 0; i < NB_OUT; i++) begin
            out_b               = |(s & top_sel);
            fb                  = out_b ^ (|(s & tap_sel));
            bits[NB_OUT-1-i]    = out_b;
            s                   = {s[LFSR_W-2:0], fb} & mask;
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_par.sv
// Parallel PRBS7/9/15/23/31 source with valid/ready output, seed reload and
// single-word error injection on o_data[0].
module prbs_par
    import prbs_pkg::*;
#(
    parameter int unsigned NB_OUT   = 2,
    parameter logic [30:0] SEED     = 31'h1AA,
    parameter logic [2:0]  MODE_RST = 3'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              i_load,
    input  logic [2:0]        i_mode,
    input  logic [30:0]       i_seed,
    input  logic              i_inj,
    input  logic              i_ready,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_valid
);

    localparam prbs_mode_e        RST_MODE  = mode_decode(MODE_RST);
    localparam logic [LFSR_W-1:0] RST_STATE = guard_seed(SEED, RST_MODE);

    logic [LFSR_W-1:0] state_q, state_d;
    prbs_mode_e        mode_q, mode_d;
    logic              inj_q, inj_d;
    logic [NB_OUT-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic [LFSR_W-1:0] step_state;
    logic [NB_OUT-1:0] step_bits;
    logic              adv;
    prbs_mode_e        load_mode;

    prbs_step #(
        .NB_OUT(NB_OUT)
    ) u_step (
        .state     (state_q),
        .mode      (mode_q),
        .next_state(step_state),
        .bits      (step_bits)
    );

    assign load_mode = mode_decode(i_mode);
    assign adv       = enable & (~valid_q | i_ready) & ~i_load;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        inj_d   = inj_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (i_load) begin
            state_d = guard_seed(i_seed, load_mode);
            mode_d  = load_mode;
            inj_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (adv) begin
                state_d = step_state;
                data_d  = step_bits ^ {{(NB_OUT-1){1'b0}}, inj_q};
                valid_d = 1'b1;
            end else if (i_ready && valid_q) begin
                valid_d = 1'b0;
            end
            // A pulse arriving while one is already pending is absorbed.
            if (adv && inj_q) begin
                inj_d = 1'b0;
            end else begin
                inj_d = inj_q | i_inj;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            mode_q  <= RST_MODE;
            inj_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            inj_q   <= inj_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule
